// File: rtl/setuphold_stim_gen.sv
// Setup/hold stimulus generator: one TCLK period per accepted command, with TD moved
// by a signed offset relative to the TCLK rise and an expected-violation flag.
module setuphold_stim_gen #(
  parameter int HALF_PERIOD = 16,
  parameter int OFS_W       = 6,
  parameter int SETUP_LIM   = 3,
  parameter int HOLD_LIM    = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic             CMD_D,
  input  logic [OFS_W-1:0] CMD_OFS,
  output logic             TCLK,
  output logic             TD,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic             EXP_VIOL
);

  localparam int CNT_W = $clog2(2 * HALF_PERIOD);
  localparam logic [CNT_W-1:0] H_CNT    = CNT_W'(HALF_PERIOD);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * HALF_PERIOD - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] td_tick_q, td_tick_d;
  logic             d_q, d_d;
  logic             tclk_q, tclk_d;
  logic             td_q, td_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             viol_q, viol_d;

  logic signed [31:0] ofs_ext;
  logic               ofs_legal;
  logic               in_window;
  logic               accept;
  logic [CNT_W-1:0]   next_cnt;

  assign ofs_ext   = {{(32 - OFS_W){CMD_OFS[OFS_W-1]}}, CMD_OFS};
  assign ofs_legal = (ofs_ext > -HALF_PERIOD) && (ofs_ext < HALF_PERIOD);
  assign in_window = (ofs_ext > -SETUP_LIM) && (ofs_ext < HOLD_LIM);
  assign CMD_READY = RST_N && (state_q == IDLE);
  assign accept    = CMD_VALID && CMD_READY;
  assign next_cnt  = cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    td_tick_d = td_tick_q;
    d_d       = d_q;
    tclk_d    = tclk_q;
    td_d      = td_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    viol_d    = viol_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ofs_legal) begin
            state_d   = RUN;
            cnt_d     = '0;
            d_d       = CMD_D;
            // Legal offsets place the TD edge strictly inside 1..2H-1.
            td_tick_d = CNT_W'(HALF_PERIOD + ofs_ext);
            busy_d    = 1'b1;
            tclk_d    = 1'b0;
            viol_d    = (CMD_D != td_q) && in_window;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tclk_d  = 1'b0;
        end else begin
          cnt_d  = next_cnt;
          tclk_d = (next_cnt >= H_CNT);
          if (next_cnt >= td_tick_q) begin
            td_d = d_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      td_tick_q <= '0;
      d_q       <= 1'b0;
      tclk_q    <= 1'b0;
      td_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      viol_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      td_tick_q <= td_tick_d;
      d_q       <= d_d;
      tclk_q    <= tclk_d;
      td_q      <= td_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      viol_q    <= viol_d;
    end
  end

  assign TCLK     = tclk_q;
  assign TD       = td_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign EXP_VIOL = viol_q;

endmodule
